// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, FSM state encoding and small address helpers for the
// instruction-fetch controller.
package fetch_ctrl_pkg;

    localparam int WORD_LEN  = 32;
    localparam int ADDR_SIZE = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [ADDR_SIZE-1:0] align_pc(input logic [ADDR_SIZE-1:0] pc);
        return pc & ~{{(ADDR_SIZE-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response and fetch-to-decode handshake bundle.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic                 imem_req;
    logic [ADDR_SIZE-1:0] imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [WORD_LEN-1:0]  imem_rdata;
    logic                 if_valid;
    logic [ADDR_SIZE-1:0] if_pc;
    logic [WORD_LEN-1:0]  if_instr;
    logic                 id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

endinterface

// File: rtl/fetch_ctrl_addr_adder1.sv
// Sequential-PC incrementer: next word address.
module addr_adder1
    import fetch_ctrl_pkg::*;
(
    input  logic [ADDR_SIZE-1:0] a,
    output logic [ADDR_SIZE-1:0] y
);

    assign y = a + 32'd4;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding memory request, a one-entry
// holding register towards decode, and redirect handling with stale-response drop.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h80000000
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] pc_cur,
    output logic                 pc_en,
    output logic [ADDR_SIZE-1:0] pc_next,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    input  logic                 stall,
    output logic [31:0]          fetch_cnt,
    fetch_ctrl_if.master         bus
);

    // RESET_VEC only mirrors the external PC register reset value.
    if (RESET_VEC[1:0] != 2'b00) begin : g_bad_reset_vec
        $error("RESET_VEC must be word aligned");
    end

    fetch_state_t         state_r, state_s;
    logic [ADDR_SIZE-1:0] pc_plus4_s;
    logic [ADDR_SIZE-1:0] if_pc_r;
    logic [WORD_LEN-1:0]  if_instr_r;
    logic [31:0]          fetch_cnt_r;
    logic                 req_s, accept_s, outstanding_s;
    logic                 capture_pc_s, capture_instr_s, count_s;

    addr_adder1 u_pc_add (.a(pc_cur), .y(pc_plus4_s));

    assign req_s    = (state_r == ST_REQ) && !stall;
    assign accept_s = req_s && bus.imem_gnt;
    // A response is still owed if a request was just granted or has not yet returned.
    assign outstanding_s = accept_s
                         || ((state_r == ST_WAIT) && !bus.imem_rvalid)
                         || ((state_r == ST_DROP) && !bus.imem_rvalid);

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = pc_cur;
    assign bus.if_pc     = if_pc_r;
    assign bus.if_instr  = if_instr_r;
    assign fetch_cnt     = fetch_cnt_r;

    // Next-state, PC update and handshake decode.
    always_comb begin
        state_s         = state_r;
        pc_en           = 1'b0;
        pc_next         = {ADDR_SIZE{1'b0}};
        bus.if_valid    = 1'b0;
        capture_pc_s    = 1'b0;
        capture_instr_s = 1'b0;
        count_s         = 1'b0;
        if (redirect) begin
            pc_en   = 1'b1;
            pc_next = align_pc(redirect_pc);
            state_s = outstanding_s ? ST_DROP : ST_REQ;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_REQ;
                ST_REQ: begin
                    if (accept_s) begin
                        pc_en        = 1'b1;
                        pc_next      = pc_plus4_s;
                        capture_pc_s = 1'b1;
                        state_s      = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        capture_instr_s = 1'b1;
                        state_s         = ST_HOLD;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    bus.if_valid = 1'b1;
                    if (bus.id_ready) begin
                        count_s = 1'b1;
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_DROP: begin
                    if (bus.imem_rvalid) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Presented PC/instruction and transfer counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_pc_r     <= {ADDR_SIZE{1'b0}};
            if_instr_r  <= {WORD_LEN{1'b0}};
            fetch_cnt_r <= 32'd0;
        end else begin
            if (capture_pc_s)    if_pc_r     <= pc_cur;
            if (capture_instr_s) if_instr_r  <= bus.imem_rdata;
            if (count_s)         fetch_cnt_r <= fetch_cnt_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an external PC register model and a
// scoreboard of expected decode transfers checked by an independent monitor.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] fetch_cnt;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_VEC(32'h80000000)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_cur     (pc_cur),
        .pc_en      (pc_en),
        .pc_next    (pc_next),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .fetch_cnt  (fetch_cnt),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // External PC register the controller steers.
    always @(posedge clk or posedge reset) begin
        if (reset)      pc_cur <= 32'h80000000;
        else if (pc_en) pc_cur <= pc_next;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every decode transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && bus.if_valid && bus.id_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual_pc=%h expected=none", bus.if_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_pc", bus.if_pc, mon_e.pc);
                chk("sb_instr", bus.if_instr, mon_e.instr);
            end
        end
    end

    // Full fetch starting in REQ: gnt now, rvalid next cycle, accepted in HOLD.
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] instr);
        bus.imem_gnt = 1'b1;
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("req", {31'd0, bus.imem_req}, 32'd1);
        chk("addr", bus.imem_addr, pc);
        chk("pc_en", {31'd0, pc_en}, 32'd1);
        chk("pc_next", pc_next, pc + 32'd4);
        sb.push_back('{pc: pc, instr: instr});
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = instr;
        @(negedge clk);
        chk("wait_valid", {31'd0, bus.if_valid}, 32'd0);
        step();
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        chk("hold_valid", {31'd0, bus.if_valid}, 32'd1);
        exp_cnt = exp_cnt + 32'd1;
        step();
        chk("fetch_cnt", fetch_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        redirect        = 1'b0;
        redirect_pc     = 32'd0;
        stall           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.id_ready    = 1'b0;
        exp_cnt         = 32'd0;
        step();
        step();
        @(negedge clk);
        chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_pc_next", pc_next, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        step();
        reset = 1'b0;
        step();

        // Basic fetch from the reset vector.
        fetch_one(32'h80000000, 32'h00000013);

        // Stall held in REQ for five cycles, grant offered but ignored.
        stall        = 1'b1;
        bus.imem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
            chk("stall_pc_en", {31'd0, pc_en}, 32'd0);
            step();
        end
        stall = 1'b0;
        fetch_one(32'h80000004, 32'h00100093);

        // Redirect while waiting: response is dropped.
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        chk("w_pc_next", pc_next, 32'h8000000C);
        step();
        bus.imem_gnt = 1'b0;
        redirect     = 1'b1;
        redirect_pc  = 32'h80000103;
        @(negedge clk);
        chk("rw_pc_en", {31'd0, pc_en}, 32'd1);
        chk("rw_pc_next", pc_next, 32'h80000100);
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("drop_req", {31'd0, bus.imem_req}, 32'd0);
        chk("drop_pc_en", {31'd0, pc_en}, 32'd0);
        step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        chk("drop_valid", {31'd0, bus.if_valid}, 32'd0);
        step();
        bus.imem_rvalid = 1'b0;
        chk("drop_cnt", fetch_cnt, 32'd2);
        fetch_one(32'h80000100, 32'h00200113);

        // Redirect coincident with grant.
        bus.imem_gnt = 1'b1;
        redirect     = 1'b1;
        redirect_pc  = 32'h80000200;
        @(negedge clk);
        chk("rg_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rg_pc_next", pc_next, 32'h80000200);
        step();
        bus.imem_gnt    = 1'b0;
        redirect        = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBADBAD00;
        @(negedge clk);
        chk("rg_drop_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rg_drop_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        bus.imem_rvalid = 1'b0;
        fetch_one(32'h80000200, 32'h00300193);

        // HOLD back-pressured for four cycles, then killed by redirect.
        bus.imem_gnt = 1'b1;
        bus.id_ready = 1'b0;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h00400213;
        step();
        bus.imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_valid4", {31'd0, bus.if_valid}, 32'd1);
            chk("hold_pc", bus.if_pc, 32'h80000204);
            chk("hold_instr", bus.if_instr, 32'h00400213);
            step();
        end
        redirect     = 1'b1;
        redirect_pc  = 32'h80000300;
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("kill_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("kill_pc_next", pc_next, 32'h80000300);
        step();
        redirect = 1'b0;
        chk("kill_cnt", fetch_cnt, 32'd4);
        fetch_one(32'h80000300, 32'h00000073);

        // Counter wrap.
        force dut.fetch_cnt_r = 32'hFFFFFFFF;
        #1;
        release dut.fetch_cnt_r;
        exp_cnt = 32'hFFFFFFFF;
        fetch_one(32'h80000304, 32'h00500293);

        // Reset mid-request, then a late response must be ignored.
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        chk("mr_pc_en", {31'd0, pc_en}, 32'd0);
        chk("mr_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mr_if_pc", bus.if_pc, 32'd0);
        step();
        reset           = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hCAFEF00D;
        exp_cnt         = 32'd0;
        step();
        @(negedge clk);
        chk("late_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("late_addr", bus.imem_addr, 32'h80000000);
        step();
        bus.imem_rvalid = 1'b0;
        fetch_one(32'h80000000, 32'h00600313);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
